// File: rtl/cfg_updown_counter.sv
// Up/down counter with a runtime terminal value, load/hold, wrap or saturate
// at the limits, and a prescaler that sets how many eligible cycles make one step.
module cfg_updown_counter #(
  parameter  int WIDTH    = 8,
  parameter  int PRESCALE = 1,
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic             up,
  input  logic             saturate,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             step,
  output logic             at_zero,
  output logic             at_max
);

  logic [WIDTH-1:0] r_count;
  logic [PS_W-1:0]  r_ps;
  logic             r_tc;
  logic             r_step;

  logic             w_ps_done;
  logic             w_bnd;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] m);
    return (v > m) ? m : v;
  endfunction

  // Compare before add/subtract so the all-ones count never overflows.
  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] cnt,
                                              input logic [WIDTH-1:0] m,
                                              input logic             dir_up,
                                              input logic             sat);
    if (dir_up) begin
      if (cnt >= m) return sat ? m : '0;
      return cnt + WIDTH'(1);
    end
    if (cnt == '0) return sat ? '0 : m;
    return cnt - WIDTH'(1);
  endfunction

  assign w_ps_done  = (r_ps == PS_W'(PRESCALE - 1));
  assign w_bnd      = up ? (r_count >= max_value) : (r_count == '0);
  assign w_next     = f_next(r_count, max_value, up, saturate);
  assign w_load_val = f_clamp(load_value, max_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ps    <= '0;
      r_tc    <= 1'b0;
      r_step  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_ps    <= '0;
      r_tc    <= 1'b0;
      r_step  <= 1'b0;
    end else if (hold) begin
      r_tc    <= 1'b0;
      r_step  <= 1'b0;
    end else if (w_ps_done) begin
      r_count <= w_next;
      r_ps    <= '0;
      r_tc    <= w_bnd;
      r_step  <= 1'b1;
    end else begin
      r_ps    <= r_ps + PS_W'(1);
      r_tc    <= 1'b0;
      r_step  <= 1'b0;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign step    = r_step;
  assign at_zero = (r_count == '0);
  assign at_max  = (r_count >= max_value);

endmodule
